// File: rtl/uart_pkg.sv
// Shared constants and state types for the APB UART: register map, bit
// positions, parity encoding and the TX/RX serialiser states.
package uart_pkg;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegBaud   = 2'd3;

  localparam int unsigned StTxFull  = 0;
  localparam int unsigned StTxEmpty = 1;
  localparam int unsigned StRxFull  = 2;
  localparam int unsigned StRxEmpty = 3;
  localparam int unsigned StTxBusy  = 4;
  localparam int unsigned StOverrun = 5;
  localparam int unsigned StParErr  = 6;
  localparam int unsigned StFrmErr  = 7;

  localparam int unsigned CtrlTxEn    = 0;
  localparam int unsigned CtrlRxEn    = 1;
  localparam int unsigned CtrlTwoStop = 4;
  localparam int unsigned CtrlIrqRx   = 5;
  localparam int unsigned CtrlIrqErr  = 6;

  localparam logic [15:0] MinBaud = 16'd4;

  typedef enum logic [1:0] {
    ParNone    = 2'b00,
    ParEven    = 2'b01,
    ParOdd     = 2'b10,
    ParNoneAlt = 2'b11
  } parity_e;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FullCount);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & !o_empty;
  assign w_do_push = i_push & (!o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_apb_fifo.sv
// APB-attached UART with TX/RX FIFOs, programmable divisor, optional parity
// and one or two stop bits. Frame settings are latched per frame.
module uart_apb_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BAUD_RST   = 50
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [31:0] i_padd,
  input  logic [31:0] i_pwdata,
  input  logic [3:0]  i_pstrb,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_pslverr,
  input  logic        i_ser_in,
  output logic        o_ser_out,
  output logic        o_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  logic [6:0]  r_ctrl;
  logic [15:0] r_baud;
  logic        r_overrun, r_par_err, r_frm_err;

  logic                 w_access, w_mapped, w_wr, w_rd, w_err;
  logic [1:0]           w_addr;
  logic                 w_tx_push, w_rx_pop, w_status_wr, w_ctrl_wr, w_baud_wr;
  logic [7:0]           w_status;
  logic                 w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [DATA_BITS-1:0] w_tx_rdata, w_rx_rdata;
  logic [CW-1:0]        w_tx_count, w_rx_count;
  logic                 w_tx_en, w_rx_en, w_par_en, w_par_odd;
  parity_e              w_par;

  // APB decode
  assign w_access = i_psel & i_penable;
  assign w_mapped = (i_padd[31:4] == 28'd0);
  assign w_addr   = i_padd[3:2];
  assign w_wr     = w_access & i_pwrite & w_mapped;
  assign w_rd     = w_access & !i_pwrite & w_mapped;

  always_comb begin
    w_err = 1'b0;
    if (w_access) begin
      if (!w_mapped) begin
        w_err = 1'b1;
      end else begin
        case (w_addr)
          RegData: w_err = i_pwrite ? (w_tx_full | !i_pstrb[0]) : w_rx_empty;
          RegBaud: w_err = i_pwrite & (i_pwdata[15:0] < MinBaud);
          default: w_err = 1'b0;
        endcase
      end
    end
  end

  assign w_tx_push   = w_wr & (w_addr == RegData) & !w_err;
  assign w_rx_pop    = w_rd & (w_addr == RegData) & !w_err;
  assign w_status_wr = w_wr & (w_addr == RegStatus);
  assign w_ctrl_wr   = w_wr & (w_addr == RegCtrl);
  assign w_baud_wr   = w_wr & (w_addr == RegBaud) & !w_err;

  assign o_pready  = w_access;
  assign o_pslverr = w_err;

  always_comb begin
    o_prdata = '0;
    if (w_rd) begin
      case (w_addr)
        RegData:   if (!w_rx_empty) o_prdata[DATA_BITS-1:0] = w_rx_rdata;
        RegStatus: o_prdata[7:0] = w_status;
        RegCtrl:   o_prdata[6:0] = r_ctrl;
        default:   o_prdata[15:0] = r_baud;
      endcase
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_ctrl <= '0;
      r_baud <= 16'(BAUD_RST);
    end else begin
      if (w_ctrl_wr) r_ctrl <= i_pwdata[6:0];
      if (w_baud_wr) r_baud <= i_pwdata[15:0];
    end
  end

  assign w_tx_en   = r_ctrl[CtrlTxEn];
  assign w_rx_en   = r_ctrl[CtrlRxEn];
  assign w_par     = parity_e'(r_ctrl[3:2]);
  assign w_par_en  = (w_par == ParEven) || (w_par == ParOdd);
  assign w_par_odd = (w_par == ParOdd);

  // Transmitter
  tx_state_e            r_tx_state;
  logic [15:0]          r_tx_cnt, r_tx_baud;
  logic [2:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par_en, r_tx_par_bit, r_tx_two_stop, r_tx_stop2, r_ser_out;
  logic                 w_tx_bit_end, w_tx_last_stop, w_tx_start, w_tx_busy;

  assign w_tx_bit_end   = (r_tx_cnt == r_tx_baud - 16'd1);
  assign w_tx_last_stop = (r_tx_state == TxStop) & w_tx_bit_end & (!r_tx_two_stop | r_tx_stop2);
  assign w_tx_start     = w_tx_en & !w_tx_empty & ((r_tx_state == TxIdle) | w_tx_last_stop);
  assign w_tx_busy      = (r_tx_state != TxIdle);
  assign o_ser_out      = r_ser_out;

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_tx_state    <= TxIdle;
      r_tx_cnt      <= '0;
      r_tx_baud     <= 16'(BAUD_RST);
      r_tx_bit      <= '0;
      r_tx_shift    <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
      r_tx_two_stop <= 1'b0;
      r_tx_stop2    <= 1'b0;
      r_ser_out     <= 1'b1;
    end else if (w_tx_start) begin
      r_tx_state    <= TxStart;
      r_tx_cnt      <= '0;
      r_tx_baud     <= r_baud;
      r_tx_bit      <= '0;
      r_tx_shift    <= w_tx_rdata;
      r_tx_par_en   <= w_par_en;
      r_tx_par_bit  <= (^w_tx_rdata) ^ w_par_odd;
      r_tx_two_stop <= r_ctrl[CtrlTwoStop];
      r_tx_stop2    <= 1'b0;
      r_ser_out     <= 1'b0;
    end else if (r_tx_state != TxIdle) begin
      if (!w_tx_bit_end) begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end else begin
        r_tx_cnt <= '0;
        case (r_tx_state)
          TxStart: begin
            r_tx_state <= TxData;
            r_ser_out  <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
          end
          TxData: begin
            if (r_tx_bit == LastBit) begin
              r_tx_state <= r_tx_par_en ? TxParity : TxStop;
              r_ser_out  <= r_tx_par_en ? r_tx_par_bit : 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_ser_out  <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end
          TxParity: begin
            r_tx_state <= TxStop;
            r_ser_out  <= 1'b1;
          end
          default: begin
            if (r_tx_two_stop && !r_tx_stop2) r_tx_stop2 <= 1'b1;
            else                              r_tx_state <= TxIdle;
          end
        endcase
      end
    end
  end

  // Receiver
  logic [1:0]           r_rx_sync;
  logic                 r_rx_prev;
  rx_state_e            r_rx_state;
  logic [15:0]          r_rx_cnt, r_rx_baud;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
  logic                 r_rx_par_en, r_rx_par_odd, r_rx_two_stop, r_rx_stop2;
  logic                 r_rx_par_ok, r_rx_stop_ok, r_rx_push;
  logic                 w_rx_bit, w_rx_fall, w_rx_sample, w_rx_done;
  logic                 w_frm_set, w_par_set, w_rx_ok, w_ovr_set;

  assign w_rx_bit    = r_rx_sync[1];
  assign w_rx_fall   = r_rx_prev & !w_rx_bit;
  assign w_rx_sample = (r_rx_state == RxStart) ? (r_rx_cnt == (r_rx_baud >> 1) - 16'd1)
                                               : (r_rx_cnt == r_rx_baud - 16'd1);
  assign w_rx_done   = (r_rx_state == RxStop) & w_rx_sample & (!r_rx_two_stop | r_rx_stop2);
  assign w_frm_set   = w_rx_done & (!w_rx_bit | !r_rx_stop_ok);
  assign w_par_set   = w_rx_done & !w_frm_set & !r_rx_par_ok;
  assign w_rx_ok     = w_rx_done & !w_frm_set & !w_par_set;
  // The push lands one cycle after the stop sample, so overrun is judged then.
  assign w_ovr_set   = r_rx_push & w_rx_full & !w_rx_pop;

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_rx_sync     <= 2'b11;
      r_rx_prev     <= 1'b1;
      r_rx_state    <= RxIdle;
      r_rx_cnt      <= '0;
      r_rx_baud     <= 16'(BAUD_RST);
      r_rx_bit      <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_par_en   <= 1'b0;
      r_rx_par_odd  <= 1'b0;
      r_rx_two_stop <= 1'b0;
      r_rx_stop2    <= 1'b0;
      r_rx_par_ok   <= 1'b1;
      r_rx_stop_ok  <= 1'b1;
      r_rx_push     <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], i_ser_in};
      r_rx_prev <= w_rx_bit;
      r_rx_push <= w_rx_ok;
      if (w_rx_done) r_rx_data <= r_rx_shift;
      case (r_rx_state)
        RxIdle: begin
          if (w_rx_en && w_rx_fall) begin
            r_rx_state    <= RxStart;
            r_rx_cnt      <= '0;
            r_rx_baud     <= r_baud;
            r_rx_bit      <= '0;
            r_rx_par_en   <= w_par_en;
            r_rx_par_odd  <= w_par_odd;
            r_rx_two_stop <= r_ctrl[CtrlTwoStop];
            r_rx_stop2    <= 1'b0;
            r_rx_par_ok   <= 1'b1;
            r_rx_stop_ok  <= 1'b1;
          end
        end
        default: begin
          if (!w_rx_sample) begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end else begin
            r_rx_cnt <= '0;
            case (r_rx_state)
              RxStart: r_rx_state <= w_rx_bit ? RxIdle : RxData;
              RxData: begin
                r_rx_shift <= {w_rx_bit, r_rx_shift[DATA_BITS-1:1]};
                if (r_rx_bit == LastBit) r_rx_state <= r_rx_par_en ? RxParity : RxStop;
                else                     r_rx_bit   <= r_rx_bit + 3'd1;
              end
              RxParity: begin
                r_rx_par_ok <= (w_rx_bit == ((^r_rx_shift) ^ r_rx_par_odd));
                r_rx_state  <= RxStop;
              end
              default: begin
                if (r_rx_two_stop && !r_rx_stop2) begin
                  r_rx_stop2   <= 1'b1;
                  r_rx_stop_ok <= w_rx_bit;
                end else begin
                  r_rx_state <= RxIdle;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_overrun <= (r_overrun & !(w_status_wr & i_pwdata[StOverrun])) | w_ovr_set;
      r_par_err <= (r_par_err & !(w_status_wr & i_pwdata[StParErr])) | w_par_set;
      r_frm_err <= (r_frm_err & !(w_status_wr & i_pwdata[StFrmErr])) | w_frm_set;
    end
  end

  assign w_status = {r_frm_err, r_par_err, r_overrun, w_tx_busy,
                     w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

  assign o_irq = (r_ctrl[CtrlIrqRx] & !w_rx_empty) | (r_ctrl[CtrlIrqErr] & (|w_status[7:5]));

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_pclk),
    .i_rst   (i_rst),
    .i_push  (w_tx_push),
    .i_wdata (i_pwdata[DATA_BITS-1:0]),
    .i_pop   (w_tx_start),
    .o_rdata (w_tx_rdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk   (i_pclk),
    .i_rst   (i_rst),
    .i_push  (r_rx_push),
    .i_wdata (r_rx_data),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_rdata),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  logic w_unused;
  assign w_unused = ^{i_padd[1:0], i_pwdata[31:16], i_pstrb[3:1], w_tx_count, w_rx_count};

endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed bench for uart_apb_fifo: APB register checks, loopback frames
// against a bit-level model, and an RX scoreboard of expected bytes.
module tb_uart_apb_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] padd = '0, pwdata = '0;
  logic [3:0]  pstrb = 4'hf;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        ser_in, ser_out, irq;
  logic        loop_en = 1'b1;
  logic        inj = 1'b1;

  assign ser_in = loop_en ? ser_out : inj;

  always #5 clk = ~clk;

  uart_apb_fifo #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (8),
    .BAUD_RST   (50)
  ) dut (
    .i_pclk    (clk),
    .i_rst     (rst),
    .i_psel    (psel),
    .i_penable (penable),
    .i_pwrite  (pwrite),
    .i_padd    (padd),
    .i_pwdata  (pwdata),
    .i_pstrb   (pstrb),
    .o_prdata  (prdata),
    .o_pready  (pready),
    .o_pslverr (pslverr),
    .i_ser_in  (ser_in),
    .o_ser_out (ser_out),
    .o_irq     (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; padd = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; padd = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Start, 8 data bits LSB-first, parity, stop, as an 11-bit LSB-first vector.
  function automatic logic [10:0] frame(input logic [7:0] d, input logic odd);
    return {1'b1, (^d) ^ odd, d, 1'b0};
  endfunction

  function automatic logic [87:0] expand(input logic [10:0] f);
    logic [87:0] v;
    for (int k = 0; k < 11; k++)
      for (int j = 0; j < 8; j++) v[8*k+j] = f[k];
    return v;
  endfunction

  task automatic capture(output logic [87:0] cap);
    for (int i = 0; i < 88; i++) begin
      @(posedge clk); #1;
      cap[i] = ser_out;
    end
  endtask

  task automatic inject(input logic [10:0] f);
    @(posedge clk); #1;
    for (int k = 0; k < 11; k++) begin
      inj = f[k];
      repeat (8) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [87:0] cap;
    logic [7:0]  txb [8];
    logic [7:0]  exp_b;
    logic [10:0] f;
    bit          got;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ser_out", ser_out, 1'b1);
    chk("rst_irq", irq, 1'b0);
    chk("rst_pready", pready, 1'b0);
    chk("rst_pslverr", pslverr, 1'b0);
    chk("rst_prdata", prdata, 32'h0);
    apb_rd(32'hC, rd, err);
    chk("rst_baud", rd, 32'd50);
    apb_rd(32'h4, rd, err);
    chk("rst_status", rd, 32'h0A);
    apb_rd(32'h8, rd, err);
    chk("rst_ctrl", rd, 32'h0);

    // Error responses
    apb_wr(32'h0, 32'h55, 4'h0, err);
    chk("wr_nostrb_err", err, 1'b1);
    apb_rd(32'h4, rd, err);
    chk("nostrb_tx_empty", rd[1], 1'b1);
    apb_rd(32'h0, rd, err);
    chk("rd_empty_err", err, 1'b1);
    chk("rd_empty_data", rd, 32'h0);
    apb_wr(32'hC, 32'd3, 4'hf, err);
    chk("baud3_err", err, 1'b1);
    apb_rd(32'hC, rd, err);
    chk("baud3_unchanged", rd, 32'd50);
    apb_rd(32'h10, rd, err);
    chk("unmapped_err", err, 1'b1);

    // Loopback, even parity
    apb_wr(32'hC, 32'd8, 4'hf, err);
    chk("baud8_ok", err, 1'b0);
    apb_wr(32'h8, 32'h07, 4'hf, err);
    apb_wr(32'h0, 32'hE7, 4'hf, err);
    sb.push_back(8'hE7);
    chk("e7_wr_ok", err, 1'b0);
    chk("tx_not_yet_low", ser_out, 1'b1);
    capture(cap);
    chk("e7_waveform", cap, expand(11'b1_0_11100111_0));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      apb_rd(32'h4, rd, err);
      got = !rd[3];
    end
    chk("e7_rx_arrived", got, 1'b1);
    apb_rd(32'h0, rd, err);
    exp_b = sb.pop_front();
    chk("e7_rx_data", rd, {24'h0, exp_b});
    chk("e7_rx_err", err, 1'b0);

    // TX FIFO full, then back-to-back frames
    apb_wr(32'h8, 32'h06, 4'hf, err);
    for (int i = 0; i < 8; i++) begin
      txb[i] = 8'h31 + 8'(i * 29);
      apb_wr(32'h0, {24'h0, txb[i]}, 4'hf, err);
      sb.push_back(txb[i]);
      chk("fill_wr_ok", err, 1'b0);
    end
    apb_wr(32'h0, 32'hFF, 4'hf, err);
    chk("ninth_wr_err", err, 1'b1);
    apb_rd(32'h4, rd, err);
    chk("tx_full_flag", rd[0], 1'b1);
    apb_wr(32'h8, 32'h07, 4'hf, err);
    for (int i = 0; i < 8; i++) begin
      capture(cap);
      chk("b2b_frame", cap, expand(frame(txb[i], 1'b0)));
    end
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      apb_rd(32'h0, rd, err);
      exp_b = sb.pop_front();
      chk("b2b_rx_data", rd, {24'h0, exp_b});
    end

    // Overrun: nine frames, no reads
    apb_wr(32'h8, 32'h27, 4'hf, err);
    for (int i = 0; i < 9; i++) begin
      apb_wr(32'h0, 32'hA0 + i, 4'hf, err);
      if (i < 8) sb.push_back(8'hA0 + 8'(i));
    end
    got = 1'b0;
    for (int i = 0; i < 1500 && !got; i++) begin
      apb_rd(32'h4, rd, err);
      got = rd[5];
    end
    chk("overrun_set", got, 1'b1);
    chk("overrun_rx_full", rd[2], 1'b1);
    chk("irq_rx", irq, 1'b1);
    for (int i = 0; i < 8; i++) begin
      apb_rd(32'h0, rd, err);
      exp_b = sb.pop_front();
      chk("ovr_rx_data", rd, {24'h0, exp_b});
    end
    chk("irq_rx_drained", irq, 1'b0);
    apb_wr(32'h4, 32'h20, 4'hf, err);
    apb_rd(32'h4, rd, err);
    chk("overrun_cleared", rd, 32'h0A);

    // Injected parity and framing errors
    loop_en = 1'b0;
    apb_wr(32'h8, 32'h46, 4'hf, err);
    f = {1'b1, 1'b0, 8'h01, 1'b0};
    inject(f);
    repeat (20) @(posedge clk);
    apb_rd(32'h4, rd, err);
    chk("parity_err_status", rd, 32'h4A);
    chk("parity_err_irq", irq, 1'b1);
    apb_wr(32'h4, 32'h40, 4'hf, err);
    #1;
    chk("parity_clr_irq", irq, 1'b0);
    f = {1'b0, 1'b1, 8'h01, 1'b0};
    inject(f);
    inj = 1'b1;
    repeat (20) @(posedge clk);
    apb_rd(32'h4, rd, err);
    chk("frame_err_status", rd, 32'h8A);
    apb_wr(32'h4, 32'h80, 4'hf, err);
    apb_rd(32'h4, rd, err);
    chk("frame_err_cleared", rd, 32'h0A);

    // Reset in the middle of a TX frame
    loop_en = 1'b1;
    apb_wr(32'h8, 32'h01, 4'hf, err);
    apb_wr(32'h0, 32'h00, 4'hf, err);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_frame_low", ser_out, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_frame_rst_high", ser_out, 1'b1);
    rst = 1'b0;
    apb_rd(32'h4, rd, err);
    chk("post_rst_status", rd, 32'h0A);
    apb_rd(32'hC, rd, err);
    chk("post_rst_baud", rd, 32'd50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
